// File: rtl/alu_issue_arbiter_if.sv
// Bundle of signals between the issue-stage fabric and the ALU issue arbiter.
// The arbiter side also exposes its internal pointer and mask for observation.
interface alu_issue_arbiter_if #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
);
    logic [WF_PER_CU-1:0]    valid_entry_out;
    logic [WF_PER_CU-1:0]    alu_ready_mask;
    logic                    alu_ready;
    logic                    f_salu_branch_en;
    logic                    f_salu_branch_taken;
    logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid;
    logic                    alu_valid;
    logic [WF_ID_LENGTH-1:0] alu_wfid;
    logic [WF_ID_LENGTH-1:0] rr_ptr;
    logic [WF_PER_CU-1:0]    last_issued;

    modport master (
        output valid_entry_out, alu_ready_mask, alu_ready,
               f_salu_branch_en, f_salu_branch_taken, f_salu_branch_wfid,
        input  alu_valid, alu_wfid, rr_ptr, last_issued
    );

    modport slave (
        input  valid_entry_out, alu_ready_mask, alu_ready,
               f_salu_branch_en, f_salu_branch_taken, f_salu_branch_wfid,
        output alu_valid, alu_wfid, rr_ptr, last_issued
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin ALU issue arbiter: picks one ready wavefront per cycle, masks the
// previous winner and any wavefront being flushed by a taken SALU branch.
module alu_issue_arbiter #(
    parameter int WF_PER_CU    = 40,
    parameter int WF_ID_LENGTH = 6
) (
    input logic clk,
    input logic rst,
    alu_issue_arbiter_if.slave bus
);
    // Handshake: alu_ready sampled in cycle t means the ALU accepts an issue
    // presented in t+1; alu_valid/alu_wfid are registered and valid for exactly
    // that one cycle, with no stall once presented.

    logic [WF_ID_LENGTH-1:0] rr_q;
    logic [WF_PER_CU-1:0]    last_q;
    logic                    valid_q;
    logic [WF_ID_LENGTH-1:0] wfid_q;

    logic [WF_PER_CU-1:0]    flush;
    logic [WF_PER_CU-1:0]    cand;
    logic                    found;
    logic [WF_ID_LENGTH-1:0] winner;
    logic [WF_ID_LENGTH:0]   idx;
    logic                    grant;
    logic [WF_ID_LENGTH-1:0] rr_next;
    logic                    branch_kill;

    assign branch_kill = bus.f_salu_branch_en & bus.f_salu_branch_taken;

    // Out-of-range branch IDs match no slot, so the mask stays empty.
    always_comb begin
        flush = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            flush[i] = branch_kill && (bus.f_salu_branch_wfid == WF_ID_LENGTH'(i));
        end
    end

    assign cand = bus.valid_entry_out & bus.alu_ready_mask & ~last_q & ~flush;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < WF_PER_CU; k++) begin
            idx = {1'b0, rr_q} + (WF_ID_LENGTH+1)'(k);
            if (idx >= (WF_ID_LENGTH+1)'(WF_PER_CU)) begin
                idx = idx - (WF_ID_LENGTH+1)'(WF_PER_CU);
            end
            if (!found && cand[idx[WF_ID_LENGTH-1:0]]) begin
                found  = 1'b1;
                winner = idx[WF_ID_LENGTH-1:0];
            end
        end
    end

    assign grant   = bus.alu_ready & found;
    assign rr_next = (winner == WF_ID_LENGTH'(WF_PER_CU-1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            wfid_q  <= '0;
        end else if (grant) begin
            rr_q    <= rr_next;
            last_q  <= {{(WF_PER_CU-1){1'b0}}, 1'b1} << winner;
            valid_q <= 1'b1;
            wfid_q  <= winner;
        end else begin
            last_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    assign bus.alu_valid   = valid_q;
    assign bus.alu_wfid    = wfid_q;
    assign bus.rr_ptr      = rr_q;
    assign bus.last_issued = last_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_alu_issue_arbiter;
    localparam int N  = 40;
    localparam int WL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]  ve = '0;
    logic [N-1:0]  rm = '0;
    logic          alu_ready = 1'b0;
    logic          br_en = 1'b0;
    logic          br_taken = 1'b0;
    logic [WL-1:0] br_wfid = '0;

    always #5 clk = ~clk;

    alu_issue_arbiter_if #(.WF_PER_CU(N), .WF_ID_LENGTH(WL)) bus();

    assign bus.valid_entry_out     = ve;
    assign bus.alu_ready_mask      = rm;
    assign bus.alu_ready           = alu_ready;
    assign bus.f_salu_branch_en    = br_en;
    assign bus.f_salu_branch_taken = br_taken;
    assign bus.f_salu_branch_wfid  = br_wfid;

    alu_issue_arbiter #(.WF_PER_CU(N), .WF_ID_LENGTH(WL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model: arbitration state kept as plain integers.
    int m_rr = 0;
    int m_last = -1;
    int m_valid = 0;
    int m_wfid = 0;

    task automatic model_tick();
        int win;
        bit found;
        if (rst) begin
            m_rr = 0; m_last = -1; m_valid = 0; m_wfid = 0;
            return;
        end
        found = 0;
        win = 0;
        for (int k = 0; k < N; k++) begin
            int w;
            w = (m_rr + k) % N;
            if (!found && ve[w] && rm[w] && w != m_last &&
                !(br_en && br_taken && int'(br_wfid) == w)) begin
                found = 1;
                win = w;
            end
        end
        if (alu_ready && found) begin
            m_valid = 1; m_wfid = win; m_last = win; m_rr = (win + 1) % N;
        end else begin
            m_valid = 0; m_last = -1;
        end
    endtask

    // Valid-entry tracker model for directed scenarios.
    bit track = 0;
    bit refill = 0;
    int cyc = 0;
    int clr_cyc[N];
    int set_cyc[N];
    logic [WL-1:0] obs_q[$];
    logic [WL-1:0] exp_q[$];

    task automatic clear_tracker();
        for (int i = 0; i < N; i++) begin
            clr_cyc[i] = -1;
            set_cyc[i] = -1;
        end
    endtask

    task automatic step();
        logic [63:0] el;
        @(posedge clk);
        model_tick();
        #1;
        cyc++;
        el = '0;
        if (m_last >= 0) el[m_last] = 1'b1;
        check("alu_valid", 64'(bus.alu_valid), 64'(m_valid));
        check("alu_wfid", 64'(bus.alu_wfid), 64'(m_wfid));
        check("rr_ptr", 64'(bus.rr_ptr), 64'(m_rr));
        check("last_issued", 64'(bus.last_issued), el);
        if (bus.alu_valid) obs_q.push_back(bus.alu_wfid);
        for (int i = 0; i < N; i++) begin
            if (clr_cyc[i] == cyc) ve[i] = 1'b0;
            if (set_cyc[i] == cyc) ve[i] = 1'b1;
        end
        if (track && bus.alu_valid) begin
            clr_cyc[bus.alu_wfid] = cyc + 1;
            if (refill) set_cyc[bus.alu_wfid] = cyc + 2;
        end
    endtask

    task automatic idle_inputs();
        ve = '0; rm = '0; alu_ready = 1'b1;
        br_en = 1'b0; br_taken = 1'b0; br_wfid = '0;
        track = 0; refill = 0;
        clear_tracker();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        logic [63:0] r64;
        clear_tracker();

        // Reset held two cycles with every input high.
        ve = '1; rm = '1; alu_ready = 1'b1;
        br_en = 1'b1; br_taken = 1'b1; br_wfid = '1;
        rst = 1'b1;
        repeat (2) begin
            step();
            check("rst_valid", 64'(bus.alu_valid), 64'd0);
            check("rst_wfid", 64'(bus.alu_wfid), 64'd0);
        end
        rst = 1'b0;
        step();
        check("first_grant_valid", 64'(bus.alu_valid), 64'd1);
        check("first_grant_wfid", 64'(bus.alu_wfid), 64'd0);

        // Round-robin wrap over slots 0, 5, 39.
        do_reset();
        ve[0] = 1; ve[5] = 1; ve[39] = 1;
        rm[0] = 1; rm[5] = 1; rm[39] = 1;
        track = 1; refill = 1;
        repeat (9) begin
            step();
            if (bus.alu_valid && bus.alu_wfid == WL'(39))
                check("rr_after_39", 64'(bus.rr_ptr), 64'd0);
        end
        exp_q = '{0, 5, 39, 0, 5, 39, 0, 5, 39};
        compare_order("rr_order");

        // No double issue of a lone wavefront.
        do_reset();
        ve[12] = 1; rm[12] = 1; track = 1;
        step();
        check("single_valid", 64'(bus.alu_valid), 64'd1);
        step();
        check("no_double", 64'(bus.alu_valid), 64'd0);
        repeat (2) step();
        exp_q = '{12};
        compare_order("single_issue");

        // Back-pressure holds everything.
        do_reset();
        ve[3] = 1; ve[7] = 1; rm[3] = 1; rm[7] = 1;
        alu_ready = 1'b0;
        repeat (4) begin
            step();
            check("bp_valid", 64'(bus.alu_valid), 64'd0);
            check("bp_rr", 64'(bus.rr_ptr), 64'd0);
        end
        alu_ready = 1'b1; track = 1;
        repeat (4) step();
        exp_q = '{3, 7};
        compare_order("bp_order");

        // Taken branch on the pointer's wavefront, then the untaken variant.
        for (int tk = 1; tk >= 0; tk--) begin
            do_reset();
            ve[8] = 1; rm[8] = 1;
            step();
            check("flush_setup_rr", 64'(bus.rr_ptr), 64'd9);
            ve = '0; rm = '0;
            ve[9] = 1; ve[20] = 1; rm[9] = 1; rm[20] = 1;
            br_en = 1'b1; br_taken = tk[0]; br_wfid = WL'(9);
            step();
            check("flush_valid", 64'(bus.alu_valid), 64'd1);
            check(tk ? "flush_taken_wfid" : "flush_untaken_wfid",
                  64'(bus.alu_wfid), tk ? 64'd20 : 64'd9);
        end

        // Out-of-range flush ID leaves slot 0 alone.
        do_reset();
        ve[0] = 1; rm[0] = 1;
        br_en = 1'b1; br_taken = 1'b1; br_wfid = WL'(45);
        step();
        check("oor_flush_valid", 64'(bus.alu_valid), 64'd1);
        check("oor_flush_wfid", 64'(bus.alu_wfid), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            r64 = {$urandom(), $urandom()};
            ve = r64[N-1:0];
            r64 = {$urandom(), $urandom()};
            rm = r64[N-1:0];
            if ($urandom_range(0, 2) == 0) begin
                r64 = {$urandom(), $urandom()};
                ve = ve & r64[N-1:0] & {N{$urandom_range(0, 3) == 0}};
            end
            alu_ready = ($urandom_range(0, 4) != 0);
            br_en = $urandom_range(0, 1);
            br_taken = $urandom_range(0, 1);
            br_wfid = ($urandom_range(0, 3) == 0) ? WL'($urandom_range(0, 63))
                                                 : WL'($urandom_range(0, N - 1));
            step();
        end
        rst = 1'b0;
        obs_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Round-robin issue arbiter for the ALU issue port of the compute unit's issue stage. Each cycle it selects one wavefront that holds a valid decoded instruction and whose operands are ready. It presents the winner as a registered `alu_valid`/`alu_wfid` pair, which the valid-entry tracker consumes to clear that wavefront's entry. It keeps a rotating priority pointer for fairness. It also masks the wavefront it issued in the previous cycle, so no instruction issues twice while the valid-entry clear is still in flight.

## Interface
- `WF_PER_CU`, 40, number of wavefront slots per CU (matches `` `WF_PER_CU ``)
- `WF_ID_LENGTH`, 6, wavefront ID width (matches `` `WF_ID_LENGTH ``)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `valid_entry_out`  in  WF_PER_CU  per-wavefront valid-instruction bits from the valid-entry tracker
- `alu_ready_mask`  in  WF_PER_CU  per-wavefront scoreboard/operand-ready bits
- `alu_ready`  in  1  ALU can accept an instruction presented next cycle
- `f_salu_branch_en`  in  1  SALU branch resolve strobe
- `f_salu_branch_taken`  in  1  resolved branch is taken
- `f_salu_branch_wfid`  in  WF_ID_LENGTH  wavefront of resolving branch
- `alu_valid`  out  1  registered issue strobe
- `alu_wfid`  out  WF_ID_LENGTH  registered issued wavefront ID

## Operation
- Candidate vector, cycle t: `valid_entry_out & alu_ready_mask & ~last_issued & ~flush`.
  - `flush` is one-hot of `f_salu_branch_wfid`, gated by `f_salu_branch_en & f_salu_branch_taken`.
  - `last_issued` is a WF_PER_CU-bit register.
- Priority search starts at `rr_ptr` and runs rr_ptr, rr_ptr+1, …, WF_PER_CU-1, 0, …, rr_ptr-1. The first candidate found wins.
- Grant condition: `alu_ready` = 1 and candidate vector non-zero.
- On grant, at the clock edge:
  - `alu_valid` <= 1
  - `alu_wfid` <= winner
  - `last_issued` <= one-hot(winner)
  - `rr_ptr` <= winner+1, wrapping 39→0 (compare against WF_PER_CU-1; never wrap on 2^WF_ID_LENGTH)
- On no grant, at the clock edge:
  - `alu_valid` <= 0
  - `alu_wfid` holds its previous value (don't-care when invalid)
  - `last_issued` <= 0
  - `rr_ptr` unchanged
- `rr_ptr` width is WF_ID_LENGTH and only ever holds values 0..WF_PER_CU-1.
- Out-of-range `f_salu_branch_wfid` (40..63) produces an empty flush mask.
- Stateful elements: `rr_ptr`, `last_issued`, `alu_valid`, `alu_wfid`. Everything else is combinational.

## Timing
- Reset values, effective at the first edge with `rst`=1: `alu_valid`=0, `alu_wfid`=0, `rr_ptr`=0, `last_issued`=0. Reset overrides a same-cycle grant.
- Latency: inputs sampled in cycle t produce the issue visible in cycle t+1.
- The tracker clears the issued entry at the end of t+1, so that clear is first visible in t+2. `last_issued` masks the winner during t+1, which prevents a double issue.
- Maximum issue rate is one per cycle. The same wavefront can issue at most every other cycle.
- `alu_ready` is sampled in cycle t and refers to acceptance in t+1. When `alu_ready`=0, no grant occurs, even with candidates present.
- If a branch flush and a candidate hit the same wavefront in the same cycle, the flush wins and that wavefront is excluded. Another wavefront may still be granted that cycle.
- Single candidate equal to `rr_ptr`: it is granted, and the pointer advances by one.
- All-ones candidate vector: the winner is exactly `rr_ptr`.
- Reset asserted mid-stream: the next cycle shows `alu_valid`=0, and arbitration restarts at wavefront 0.

## Test plan
- Reset check: hold `rst` for 2 cycles with all inputs at 1 → `alu_valid`=0, `alu_wfid`=0 throughout. First grant after release is wfid 0.
- Round-robin wrap:
  - Stimulus: valid/ready bits 0, 5 and 39 held at 1, `alu_ready`=1, tracker model clears entries on issue, bits re-set 2 cycles after issue.
  - Required response: issue order 0, 5, 39, 0, 5, 39, …
  - Also check that after wfid 39 issues, `rr_ptr` reads 0.
- No double issue: only wf 12 valid and ready, with its entry cleared 2 cycles after issue → exactly one `alu_valid` pulse with wfid 12. No pulse in the following cycle, even though `valid_entry_out[12]` is still 1 in that cycle.
- Back-pressure: wf 3 and wf 7 ready, `alu_ready`=0 for 4 cycles → `alu_valid`=0 throughout and `rr_ptr` unchanged. When `alu_ready` rises, wf 3 issues first, then wf 7.
- Branch flush:
  - Stimulus: wf 9 and wf 20 candidates, `rr_ptr`=9, branch taken on wf 9 in the same cycle.
  - Required response: wf 20 issues next cycle.
  - With `f_salu_branch_taken`=0 instead, wf 9 issues.
- Out-of-range flush: `f_salu_branch_wfid`=45, taken, wf 0 sole candidate → wf 0 issues unaffected.
